alu_ctrl_seq: RTL and testbench
===============================

# alu_ctrl_seq

Registered, parametrised ALU control unit for the multi-cycle RISC-V core, placed between the main control FSM and the ALU/datapath. Decodes ALUOp/op/funct3/funct7 into a widened ALUControl code covering the full RV32I ALU set (adds SRA, SLTU, illegal detection). Optionally sequences multi-cycle M-extension operations through a start/done handshake with an external mul/div unit, stalling the main FSM while that unit works.

## Interface
- CTRL_W, default 4: ALUControl width; minimum 4.
- MD_TIMEOUT, default 64: maximum WAIT cycles before a mul/div timeout; minimum 2.

- clk  in  1  core clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- dec_valid  in  1  sample decode fields this cycle; accepted only in IDLE.
- ALUOp  in  2  class from main FSM.
- op  in  7  opcode.
- funct3  in  3  instruction funct3.
- funct7b5  in  1  instr[30].
- funct7b0  in  1  instr[25] (M-extension select).
- ALUControl  out  CTRL_W  registered ALU operation code.
- ctrl_valid  out  1  one-cycle pulse: ALUControl updated for the accepted decode.
- illegal  out  1  registered; 1 when the last accepted decode was unsupported.
- md_start  out  1  one-cycle pulse launching a mul/div op.
- md_op  out  3  funct3 of the mul/div op, held from ISSUE until the next accept.
- md_done  in  1  mul/div completion, sampled only in WAIT.
- stall  out  1  high in ISSUE and WAIT.
- md_timeout  out  1  sticky error flag; cleared only by reset.

## Operation
- Codes (zero-extended to CTRL_W): add 0000, sub 0001, and 0010, or 0011, xor 0100, slt 0101, sll 0110, srl 0111, sra 1000, sltu 1001, md 1111. The low 3 bits match the legacy 3-bit codes.
- ALUOp 00 gives add. ALUOp 01 gives sub (branch compare).
- ALUOp 10 decodes by funct3:
  - 000: sub if op[5] & funct7b5, else add.
  - 001: sll. 010: slt. 011: sltu. 100: xor.
  - 101: sra if funct7b5, else srl. This applies to both R-type and I-type.
  - 110: or. 111: and.
- ALUOp 11 is illegal: ALUControl=0000, illegal=1.
- An M-op is ALUOp 10, op[5]=1, funct7b0=1. It produces ALUControl=1111 and the mul/div sequence.
- FSM states: IDLE, ISSUE, WAIT, DONE.
  - IDLE: on dec_valid, register ALUControl and illegal. An M-op goes to ISSUE; everything else pulses ctrl_valid next cycle and stays in IDLE.
  - ISSUE: md_start=1, md_op=funct3. Always goes to WAIT next cycle.
  - WAIT: timeout counter starts at 0 on entry and increments each cycle.
    - md_done=1 goes to DONE.
    - counter==MD_TIMEOUT-1 with md_done=0 sets md_timeout and goes to IDLE with no ctrl_valid.
    - If md_done and the timeout limit coincide, md_done wins.
  - DONE: ctrl_valid=1, then IDLE.
- dec_valid outside IDLE is ignored and not queued. md_done outside WAIT is ignored.
- When rst_n is asserted mid-operation, outputs go to their reset values immediately and the FSM returns to IDLE.

## Timing
- Reset values: ALUControl=0, ctrl_valid=0, illegal=0, md_start=0, md_op=0, stall=0, md_timeout=0, state IDLE, counter 0.
- Non-M decode: dec_valid sampled at edge N; ALUControl, illegal and ctrl_valid are valid after edge N. Latency is 1 cycle and throughput is 1 per cycle.
- M decode: edge N enters ISSUE (md_start and stall high). Edge N+1 enters WAIT. The edge sampling md_done=1 enters DONE (ctrl_valid high, stall low). The following edge returns to IDLE. Minimum 3 cycles from accept to ctrl_valid.
- Outputs are all registered; there are no combinational input-to-output paths.

## Configuration
- ALU_CTRL_MEXT_EN defined: M-op decode, the ISSUE/WAIT/DONE states, the timeout counter and the md_* ports are active.
- ALU_CTRL_MEXT_EN undefined:
  - an M-op decodes as illegal=1, ALUControl=0000, with a ctrl_valid pulse;
  - md_start, md_op, stall and md_timeout are tied to 0;
  - ports remain present.

## Structure
- Package alu_ctrl_pkg holds:
  - ALU code localparams or enum;
  - ALUOp enum (LDST, BRANCH, FUNC, ILLEGAL);
  - FSM state enum;
  - OP_R=7'b0110011.
- Sub-module alu_ctrl_dec: pure combinational decode table (fields to code, illegal, is_md). The top holds the registers, FSM and counter (counter width $clog2(MD_TIMEOUT)).

## Test plan
- Reset: rst_n=0 with random inputs -> all outputs 0. Release, no dec_valid -> outputs stay 0.
- R-type sub: ALUOp=10, op=0110011, funct3=000, funct7b5=1, dec_valid -> next cycle ALUControl=0001, ctrl_valid high for one cycle. srai (op=0010011, funct3=101, funct7b5=1) -> 1000.
- ALUOp=11 -> illegal=1, ALUControl=0000. Next decode ALUOp=00 -> illegal=0, ALUControl=0000.
- div (op=0110011, funct7b0=1, funct3=100):
  - next cycle: ALUControl=1111, md_start pulse, md_op=100, stall=1;
  - md_done on the 5th WAIT cycle -> one cycle later ctrl_valid=1, stall=0.
  - Without the macro: illegal=1 and no md_start.
- MD_TIMEOUT=8, md_done never asserted -> after the 8th WAIT cycle md_timeout=1, stall=0, no ctrl_valid. dec_valid pulses during WAIT are ignored.
- rst_n asserted in the 2nd WAIT cycle -> stall and all outputs drop to 0 immediately. A later md_done is ignored.

Source files
------------

// File: rtl/alu_ctrl_pkg.sv
// Shared types and constants for the ALU control unit: ALU codes, ALUOp classes, FSM states.
package alu_ctrl_pkg;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLL  = 4'b0110;
  localparam logic [3:0] ALU_SRL  = 4'b0111;
  localparam logic [3:0] ALU_SRA  = 4'b1000;
  localparam logic [3:0] ALU_SLTU = 4'b1001;
  localparam logic [3:0] ALU_MD   = 4'b1111;

  localparam logic [6:0] OP_R = 7'b0110011;

  typedef enum logic [1:0] {
    LDST    = 2'b00,
    BRANCH  = 2'b01,
    FUNC    = 2'b10,
    ILLEGAL = 2'b11
  } alu_op_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'b00,
    S_ISSUE = 2'b01,
    S_WAIT  = 2'b10,
    S_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/alu_ctrl_seq_if.sv
// Decode/result bus between main control FSM, ALU control unit and the mul/div unit.
interface alu_ctrl_seq_if #(parameter int CTRL_W = 4);
  logic              dec_valid;
  logic [1:0]        ALUOp;
  logic [6:0]        op;
  logic [2:0]        funct3;
  logic              funct7b5;
  logic              funct7b0;
  logic [CTRL_W-1:0] ALUControl;
  logic              ctrl_valid;
  logic              illegal;
  logic              md_start;
  logic [2:0]        md_op;
  logic              md_done;
  logic              stall;
  logic              md_timeout;

  modport master (
    output dec_valid, ALUOp, op, funct3, funct7b5, funct7b0, md_done,
    input  ALUControl, ctrl_valid, illegal, md_start, md_op, stall, md_timeout
  );

  modport slave (
    input  dec_valid, ALUOp, op, funct3, funct7b5, funct7b0, md_done,
    output ALUControl, ctrl_valid, illegal, md_start, md_op, stall, md_timeout
  );
endinterface

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of ALUOp/op/funct fields into ALU code, illegal and mul/div flags.
// ALU_CTRL_MEXT_EN selects whether M-ops decode as mul/div or as illegal.
module alu_ctrl_dec
  import alu_ctrl_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       funct7b0,
  output logic [3:0] code,
  output logic       illegal,
  output logic       is_md
);

  logic m_op;
  logic unused_op;

  assign m_op      = (alu_op_e'(alu_op) == FUNC) && op[5] && funct7b0;
  assign unused_op = ^{op[6], op[4:0]};

  always_comb begin
    code    = ALU_ADD;
    illegal = 1'b0;
    is_md   = 1'b0;
    case (alu_op_e'(alu_op))
      LDST:    code = ALU_ADD;
      BRANCH:  code = ALU_SUB;
      ILLEGAL: illegal = 1'b1;
      FUNC: begin
        if (m_op) begin
`ifdef ALU_CTRL_MEXT_EN
          code  = ALU_MD;
          is_md = 1'b1;
`else
          illegal = 1'b1;
`endif
        end else begin
          case (funct3)
            3'b000:  code = (op[5] && funct7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  code = ALU_SLL;
            3'b010:  code = ALU_SLT;
            3'b011:  code = ALU_SLTU;
            3'b100:  code = ALU_XOR;
            // shift-right arithmetic selected by instr[30] for both srai and sra
            3'b101:  code = funct7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  code = ALU_OR;
            default: code = ALU_AND;
          endcase
        end
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Registered ALU control unit with mul/div start/done sequencing and timeout.
// ALU_CTRL_MEXT_EN enables the mul/div path; otherwise md_* and stall are tied low.
//
// state   | meaning
// IDLE    | accepting decodes; non-M results pulse ctrl_valid next cycle
// ISSUE   | md_start high, md_op presented to mul/div unit
// WAIT    | counting cycles until md_done or timeout
// DONE    | mul/div finished, ctrl_valid high for one cycle
module alu_ctrl_seq
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W     = 4,
  parameter int MD_TIMEOUT = 64
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_ctrl_seq_if.slave  bus
);

`ifdef ALU_CTRL_MEXT_EN
  localparam bit MEXT = 1'b1;
`else
  localparam bit MEXT = 1'b0;
`endif

  localparam int CNT_W = (MD_TIMEOUT > 2) ? $clog2(MD_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MD_TIMEOUT - 1);

  state_e            state;
  state_e            state_nx;
  logic [CNT_W-1:0]  cnt;
  logic              timeout_hit;
  logic              accept;

  logic [3:0]        dec_code;
  logic              dec_ill;
  logic              dec_md;

  logic [CTRL_W-1:0] alu_control_q;
  logic              illegal_q;
  logic              ctrl_pulse_q;
  logic [2:0]        md_op_q;
  logic              md_timeout_q;

  alu_ctrl_dec u_dec (
    .alu_op   (bus.ALUOp),
    .op       (bus.op),
    .funct3   (bus.funct3),
    .funct7b5 (bus.funct7b5),
    .funct7b0 (bus.funct7b0),
    .code     (dec_code),
    .illegal  (dec_ill),
    .is_md    (dec_md)
  );

  assign accept = (state == S_IDLE) && bus.dec_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    timeout_hit = 1'b0;
    case (state)
      S_IDLE:  if (accept && dec_md) state_nx = S_ISSUE;
      S_ISSUE: state_nx = S_WAIT;
      S_WAIT: begin
        // completion takes priority over a timeout in the same cycle
        if (bus.md_done) begin
          state_nx = S_DONE;
        end else if (cnt == CNT_LAST) begin
          state_nx    = S_IDLE;
          timeout_hit = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_control_q <= '0;
      illegal_q     <= 1'b0;
      ctrl_pulse_q  <= 1'b0;
      md_op_q       <= '0;
      md_timeout_q  <= 1'b0;
      cnt           <= '0;
    end else begin
      if (accept) begin
        alu_control_q <= CTRL_W'(dec_code);
        illegal_q     <= dec_ill;
      end
      ctrl_pulse_q <= accept && !dec_md;
      if (accept && dec_md) md_op_q <= bus.funct3;
      cnt <= (state == S_WAIT) ? cnt + CNT_W'(1) : '0;
      if (timeout_hit) md_timeout_q <= 1'b1;
    end
  end

  always_comb begin
    bus.ALUControl = alu_control_q;
    bus.illegal    = illegal_q;
    bus.ctrl_valid = ctrl_pulse_q || (state == S_DONE);
    bus.md_start   = MEXT && (state == S_ISSUE);
    bus.md_op      = MEXT ? md_op_q : 3'b000;
    bus.stall      = MEXT && ((state == S_ISSUE) || (state == S_WAIT));
    bus.md_timeout = MEXT && md_timeout_q;
  end

endmodule

// File: tb/tb_alu_ctrl_seq.sv
// Self-checking bench for alu_ctrl_seq: decode table, mul/div sequences, reset and random traffic.
module tb_alu_ctrl_seq;
  import alu_ctrl_pkg::*;

  localparam logic [6:0] OP_I = 7'b0010011;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  alu_ctrl_seq_if #(.CTRL_W(4)) bus ();

  alu_ctrl_seq #(.CTRL_W(4), .MD_TIMEOUT(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  typedef struct {
    logic [1:0] aluop;
    logic [6:0] op;
    logic [2:0] f3;
    logic       b5;
    logic       b0;
    logic [3:0] code;
    logic       ill;
  } vec_t;

  vec_t tbl[16];

  logic [3:0] exp_code;
  logic       exp_ill;
  logic       exp_to;
  logic [2:0] exp_md_op;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] code, input logic ill,
                         input logic cv, input logic ms, input logic stl, input logic mto);
    chk({tag, ".ALUControl"}, 32'(bus.ALUControl), 32'(code));
    chk({tag, ".illegal"},    32'(bus.illegal),    32'(ill));
    chk({tag, ".ctrl_valid"}, 32'(bus.ctrl_valid), 32'(cv));
    chk({tag, ".md_start"},   32'(bus.md_start),   32'(ms));
    chk({tag, ".stall"},      32'(bus.stall),      32'(stl));
    chk({tag, ".md_timeout"}, 32'(bus.md_timeout), 32'(mto));
  endtask

  task automatic drive_dec(input logic [1:0] aluop, input logic [6:0] op, input logic [2:0] f3,
                           input logic b5, input logic b0);
    bus.ALUOp     = aluop;
    bus.op        = op;
    bus.funct3    = f3;
    bus.funct7b5  = b5;
    bus.funct7b0  = b0;
    bus.dec_valid = 1'b1;
  endtask

  task automatic rand_fields;
    bus.ALUOp    = 2'($urandom_range(0, 3));
    bus.op       = 7'($urandom);
    bus.funct3   = 3'($urandom);
    bus.funct7b5 = 1'($urandom);
    bus.funct7b0 = 1'($urandom);
  endtask

  task automatic do_reset;
    bus.dec_valid = 1'b0;
    bus.md_done   = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Reference decode written straight from the instruction-set meaning of each field.
  function automatic void ref_decode(input logic [1:0] aluop, input logic [6:0] op,
                                     input logic [2:0] f3, input logic b5, input logic b0,
                                     output logic [3:0] code, output logic ill, output logic md);
    logic [3:0] f3_map [8];
    f3_map[0] = 4'd0; f3_map[1] = 4'd6; f3_map[2] = 4'd5; f3_map[3] = 4'd9;
    f3_map[4] = 4'd4; f3_map[5] = 4'd7; f3_map[6] = 4'd3; f3_map[7] = 4'd2;
    code = 4'd0;
    ill  = 1'b0;
    md   = 1'b0;
    if (aluop == 2'd1) code = 4'd1;
    else if (aluop == 2'd3) ill = 1'b1;
    else if (aluop == 2'd2) begin
      if (op[5] && b0) begin
`ifdef ALU_CTRL_MEXT_EN
        code = 4'd15;
        md   = 1'b1;
`else
        ill = 1'b1;
`endif
      end else begin
        code = f3_map[f3];
        if (f3 == 3'd0 && op[5] && b5) code = 4'd1;
        if (f3 == 3'd5 && b5) code = 4'd8;
      end
    end
  endfunction

  initial begin
    checks = 0;
    errors = 0;
    tbl[0]  = '{2'b10, OP_R, 3'b000, 1'b1, 1'b0, 4'b0001, 1'b0};
    tbl[1]  = '{2'b10, OP_R, 3'b000, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[2]  = '{2'b10, OP_I, 3'b000, 1'b1, 1'b0, 4'b0000, 1'b0};
    tbl[3]  = '{2'b10, OP_I, 3'b101, 1'b1, 1'b0, 4'b1000, 1'b0};
    tbl[4]  = '{2'b10, OP_R, 3'b101, 1'b0, 1'b0, 4'b0111, 1'b0};
    tbl[5]  = '{2'b10, OP_R, 3'b001, 1'b0, 1'b0, 4'b0110, 1'b0};
    tbl[6]  = '{2'b10, OP_R, 3'b010, 1'b0, 1'b0, 4'b0101, 1'b0};
    tbl[7]  = '{2'b10, OP_I, 3'b011, 1'b0, 1'b0, 4'b1001, 1'b0};
    tbl[8]  = '{2'b10, OP_R, 3'b100, 1'b0, 1'b0, 4'b0100, 1'b0};
    tbl[9]  = '{2'b10, OP_R, 3'b110, 1'b0, 1'b0, 4'b0011, 1'b0};
    tbl[10] = '{2'b10, OP_R, 3'b111, 1'b0, 1'b0, 4'b0010, 1'b0};
    tbl[11] = '{2'b00, OP_R, 3'b111, 1'b1, 1'b1, 4'b0000, 1'b0};
    tbl[12] = '{2'b01, OP_R, 3'b000, 1'b0, 1'b1, 4'b0001, 1'b0};
    tbl[13] = '{2'b11, OP_R, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b1};
    tbl[14] = '{2'b00, OP_I, 3'b010, 1'b0, 1'b0, 4'b0000, 1'b0};
    tbl[15] = '{2'b10, OP_I, 3'b000, 1'b0, 1'b1, 4'b0000, 1'b0};

    // reset with random inputs
    rst_n = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rand_fields();
      bus.dec_valid = 1'($urandom);
      bus.md_done   = 1'($urandom);
      #7;
      chk_out("reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      chk("reset.md_op", 32'(bus.md_op), 32'd0);
    end
    bus.dec_valid = 1'b0;
    bus.md_done   = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk_out("post_reset", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // decode table, back-to-back
    for (int i = 0; i < 16; i++) begin
      drive_dec(tbl[i].aluop, tbl[i].op, tbl[i].f3, tbl[i].b5, tbl[i].b0);
      tick();
      chk_out($sformatf("tbl%0d", i), tbl[i].code, tbl[i].ill, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    bus.dec_valid = 1'b0;
    tick();
    chk_out("tbl_end", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

`ifdef ALU_CTRL_MEXT_EN
    // div with md_done in the 5th WAIT cycle, a stray decode in WAIT ignored
    drive_dec(2'b10, OP_R, 3'b100, 1'b0, 1'b1);
    tick();
    bus.dec_valid = 1'b0;
    chk_out("div_issue", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    chk("div_issue.md_op", 32'(bus.md_op), 32'd4);
    for (int w = 1; w <= 5; w++) begin
      tick();
      chk_out($sformatf("div_wait%0d", w), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.dec_valid = (w == 2);
      bus.ALUOp     = 2'b01;
      bus.md_done   = (w == 5);
    end
    tick();
    bus.md_done = 1'b0;
    chk_out("div_done", 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("div_done.md_op", 32'(bus.md_op), 32'd4);
    tick();
    chk_out("div_idle", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // md_done on the last allowed WAIT cycle wins over the timeout
    drive_dec(2'b10, OP_R, 3'b000, 1'b0, 1'b1);
    tick();
    bus.dec_valid = 1'b0;
    chk_out("mul_issue", 4'hF, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    for (int w = 1; w <= 8; w++) begin
      tick();
      chk_out($sformatf("mul_wait%0d", w), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.md_done = (w == 8);
    end
    tick();
    bus.md_done = 1'b0;
    chk_out("mul_edge_done", 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();

    // timeout: md_done never comes, decodes during WAIT are dropped
    drive_dec(2'b10, OP_R, 3'b011, 1'b0, 1'b1);
    tick();
    chk("to_issue.md_op", 32'(bus.md_op), 32'd3);
    for (int w = 1; w <= 8; w++) begin
      tick();
      chk_out($sformatf("to_wait%0d", w), 4'hF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      bus.ALUOp     = 2'b00;
      bus.dec_valid = w[0];
    end
    tick();
    chk_out("to_expire", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    tick();
    chk_out("to_sticky", 4'hF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    drive_dec(2'b01, OP_R, 3'b000, 1'b0, 1'b0);
    tick();
    bus.dec_valid = 1'b0;
    chk_out("to_next", 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    // async reset in the 2nd WAIT cycle, later md_done ignored
    drive_dec(2'b10, OP_R, 3'b110, 1'b0, 1'b1);
    tick();
    bus.dec_valid = 1'b0;
    tick();
    tick();
    chk("rst_mid.stall_before", 32'(bus.stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    chk_out("rst_mid", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst_mid.md_op", 32'(bus.md_op), 32'd0);
    @(negedge clk);
    rst_n       = 1'b1;
    bus.md_done = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_out("rst_late_done", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    bus.md_done = 1'b0;
`else
    drive_dec(2'b10, OP_R, 3'b100, 1'b0, 1'b1);
    tick();
    bus.dec_valid = 1'b0;
    chk_out("div_nomext", 4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    chk("div_nomext.md_op", 32'(bus.md_op), 32'd0);
    tick();
    chk_out("div_nomext_idle", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

    // random traffic against the reference model
    do_reset();
    exp_code  = 4'd0;
    exp_ill   = 1'b0;
    exp_to    = 1'b0;
    exp_md_op = 3'd0;
    for (int n = 0; n < 300; n++) begin
      logic [1:0] ra;
      logic [6:0] ro;
      logic [2:0] rf;
      logic       r5, r0, e_ill, e_md;
      logic [3:0] e_code;
      int         gap;
      gap = $urandom_range(0, 2);
      for (int g = 0; g < gap; g++) begin
        rand_fields();
        bus.dec_valid = 1'b0;
        bus.md_done   = 1'($urandom);
        tick();
        chk_out("rnd_gap", exp_code, exp_ill, 1'b0, 1'b0, 1'b0, exp_to);
        chk("rnd_gap.md_op", 32'(bus.md_op), 32'(exp_md_op));
      end
      bus.md_done = 1'b0;
      ra = ($urandom_range(0, 1) == 1) ? 2'b10 : 2'($urandom);
      case ($urandom_range(0, 2))
        0:       ro = OP_R;
        1:       ro = OP_I;
        default: ro = 7'($urandom);
      endcase
      rf = 3'($urandom);
      r5 = 1'($urandom);
      r0 = 1'($urandom);
      ref_decode(ra, ro, rf, r5, r0, e_code, e_ill, e_md);
      drive_dec(ra, ro, rf, r5, r0);
      tick();
      bus.dec_valid = 1'b0;
      exp_code = e_code;
      exp_ill  = e_ill;
`ifdef ALU_CTRL_MEXT_EN
      if (e_md) begin
        int lat;
        exp_md_op = rf;
        chk_out("rnd_issue", exp_code, exp_ill, 1'b0, 1'b1, 1'b1, exp_to);
        chk("rnd_issue.md_op", 32'(bus.md_op), 32'(exp_md_op));
        lat = $urandom_range(1, 10);
        for (int w = 1; w <= 8; w++) begin
          tick();
          chk_out("rnd_wait", exp_code, exp_ill, 1'b0, 1'b0, 1'b1, exp_to);
          rand_fields();
          bus.dec_valid = 1'($urandom);
          bus.md_done   = (w == lat);
          if (w == lat) break;
        end
        tick();
        bus.dec_valid = 1'b0;
        bus.md_done   = 1'b0;
        if (lat <= 8) begin
          chk_out("rnd_done", exp_code, exp_ill, 1'b1, 1'b0, 1'b0, exp_to);
        end else begin
          exp_to = 1'b1;
          chk_out("rnd_timeout", exp_code, exp_ill, 1'b0, 1'b0, 1'b0, exp_to);
        end
        chk("rnd_end.md_op", 32'(bus.md_op), 32'(exp_md_op));
      end else
`endif
      begin
        chk_out("rnd_dec", exp_code, exp_ill, 1'b1, 1'b0, 1'b0, exp_to);
        chk("rnd_dec.md_op", 32'(bus.md_op), 32'(exp_md_op));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
